// File: rtl/mult_fu_if.sv
// Multiply-slot handshake between the issue/register-read pipeline register and mult_fu.
// The master side is the upstream slot; the slave side is the functional unit.
interface mult_fu_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 7,
    parameter int ROB_W = 6
);
    logic             in_valid;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [TAG_W-1:0] in_tag;
    logic [ROB_W-1:0] in_rob;
    logic             flush;
    logic             mult_done;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] result_tag;
    logic [ROB_W-1:0] result_rob;

    modport master (
        output in_valid, op_a, op_b, in_tag, in_rob, flush,
        input  mult_done, busy, result_valid, result, result_tag, result_rob
    );

    modport slave (
        input  in_valid, op_a, op_b, in_tag, in_rob, flush,
        output mult_done, busy, result_valid, result, result_tag, result_rob
    );
endinterface

// File: rtl/mult_fu.sv
// Radix-2 shift-add multiplier unit: one operation per WIDTH+2 cycles, low WIDTH bits of
// the product, with flush returning an abort completion so the upstream slot always frees.
module mult_fu #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 7,
    parameter int ROB_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    mult_fu_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] a_r, a_next_s;
    logic [WIDTH-1:0] b_r, b_next_s;
    logic [WIDTH-1:0] acc_r, acc_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic [TAG_W-1:0] tag_r, tag_next_s;
    logic [ROB_W-1:0] rob_r, rob_next_s;
    logic             load_result_s;
    logic             abort_s;

    logic             mult_done_r;
    logic             busy_r;
    logic             result_valid_r;
    logic [WIDTH-1:0] result_r;
    logic [TAG_W-1:0] result_tag_r;
    logic [ROB_W-1:0] result_rob_r;

    // Next-state and datapath step; flush overrides every other transition.
    always_comb begin
        state_next_s  = state_r;
        a_next_s      = a_r;
        b_next_s      = b_r;
        acc_next_s    = acc_r;
        cnt_next_s    = cnt_r;
        tag_next_s    = tag_r;
        rob_next_s    = rob_r;
        load_result_s = 1'b0;
        abort_s       = 1'b0;
        if (bus.flush) begin
            state_next_s = DONE;
            abort_s      = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_next_s     = bus.op_a;
                        b_next_s     = bus.op_b;
                        acc_next_s   = {WIDTH{1'b0}};
                        cnt_next_s   = {CNT_W{1'b0}};
                        tag_next_s   = bus.in_tag;
                        rob_next_s   = bus.in_rob;
                        state_next_s = BUSY;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                BUSY: begin
                    if (b_r[0]) begin
                        acc_next_s = acc_r + a_r;
                    end else begin
                        acc_next_s = acc_r;
                    end
                    a_next_s   = a_r << 1;
                    b_next_s   = b_r >> 1;
                    cnt_next_s = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        // cnt would wrap here; it is reloaded on the next capture anyway
                        state_next_s  = DONE;
                        load_result_s = 1'b1;
                    end else begin
                        state_next_s = BUSY;
                    end
                end
                DONE: begin
                    state_next_s = IDLE;
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand, accumulator, counter and package registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            acc_r <= {WIDTH{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            tag_r <= {TAG_W{1'b0}};
            rob_r <= {ROB_W{1'b0}};
        end else begin
            a_r   <= a_next_s;
            b_r   <= b_next_s;
            acc_r <= acc_next_s;
            cnt_r <= cnt_next_s;
            tag_r <= tag_next_s;
            rob_r <= rob_next_s;
        end
    end

    // Output registers, decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            mult_done_r    <= 1'b0;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
            result_r       <= {WIDTH{1'b0}};
            result_tag_r   <= {TAG_W{1'b0}};
            result_rob_r   <= {ROB_W{1'b0}};
        end else begin
            mult_done_r    <= (state_next_s == DONE);
            busy_r         <= (state_next_s != IDLE);
            result_valid_r <= (state_next_s == DONE) && !abort_s;
            if (load_result_s) begin
                result_r     <= acc_next_s;
                result_tag_r <= tag_r;
                result_rob_r <= rob_r;
            end else begin
                result_r     <= result_r;
                result_tag_r <= result_tag_r;
                result_rob_r <= result_rob_r;
            end
        end
    end

    assign bus.mult_done    = mult_done_r;
    assign bus.busy         = busy_r;
    assign bus.result_valid = result_valid_r;
    assign bus.result       = result_r;
    assign bus.result_tag   = result_tag_r;
    assign bus.result_rob   = result_rob_r;
endmodule

// File: tb/tb_mult_fu.sv
// Self-checking bench for mult_fu: directed table, randomized operations against an
// arithmetic reference, back-to-back slot model, flush and reset corner sequences.
module tb_mult_fu;
    localparam int WIDTH = 16;
    localparam int TAG_W = 7;
    localparam int ROB_W = 6;
    localparam int LAT   = WIDTH + 1;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
        logic [ROB_W-1:0] rob;
        logic [WIDTH-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [WIDTH-1:0] last_res;
    logic [TAG_W-1:0] last_tag;
    logic [ROB_W-1:0] last_rob;

    always #5 clk = ~clk;

    mult_fu_if #(.WIDTH(WIDTH), .TAG_W(TAG_W), .ROB_W(ROB_W)) bus ();

    mult_fu #(.WIDTH(WIDTH), .TAG_W(TAG_W), .ROB_W(ROB_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return p[WIDTH-1:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic present(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [TAG_W-1:0] tag, input logic [ROB_W-1:0] rob);
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_tag   = tag;
        bus.in_rob   = rob;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_done"}, 32'(bus.mult_done), 32'd0);
        check({nm, "_busy"}, 32'(bus.busy), 32'd0);
        check({nm, "_rv"},   32'(bus.result_valid), 32'd0);
        check({nm, "_res"},  32'(bus.result), 32'd0);
        check({nm, "_tag"},  32'(bus.result_tag), 32'd0);
        check({nm, "_rob"},  32'(bus.result_rob), 32'd0);
    endtask

    // Called at a negedge with the unit idle; returns at the negedge of the following IDLE cycle.
    task automatic run_op(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [TAG_W-1:0] tag, input logic [ROB_W-1:0] rob,
                          input logic [WIDTH-1:0] exp);
        int k;
        bit busy_ok;
        present(a, b, tag, rob);
        k = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            k++;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end while (bus.mult_done !== 1'b1 && k < 3 * LAT);
        check({nm, "_latency"}, 32'(k), 32'(LAT));
        check({nm, "_busy_high"}, 32'(busy_ok), 32'd1);
        check({nm, "_rv"},  32'(bus.result_valid), 32'd1);
        check({nm, "_res"}, 32'(bus.result), 32'(exp));
        check({nm, "_tag"}, 32'(bus.result_tag), 32'(tag));
        check({nm, "_rob"}, 32'(bus.result_rob), 32'(rob));
        last_res = exp;
        last_tag = tag;
        last_rob = rob;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({nm, "_done_1cyc"}, 32'(bus.mult_done), 32'd0);
        check({nm, "_idle"}, 32'(bus.busy), 32'd0);
        check({nm, "_hold"}, 32'(bus.result), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        logic [WIDTH-1:0] ra, rb;
        logic [TAG_W-1:0] rt;
        logic [ROB_W-1:0] rr;
        logic [WIDTH-1:0] pa[3], pb[3];
        logic [TAG_W-1:0] pt[3];
        logic [ROB_W-1:0] pr[3];
        int idx, cyc, last_cyc;
        bit saw;

        vecs[0] = '{a: 16'h0007, b: 16'h0009, tag: 7'h15, rob: 6'h2A, exp: 16'h003F};
        vecs[1] = '{a: 16'hFFFF, b: 16'hFFFF, tag: 7'h01, rob: 6'h02, exp: 16'h0001};
        vecs[2] = '{a: 16'h1234, b: 16'h0100, tag: 7'h7F, rob: 6'h3F, exp: 16'h3400};
        vecs[3] = '{a: 16'h0000, b: 16'hBEEF, tag: 7'h40, rob: 6'h11, exp: 16'h0000};

        // Reset held two cycles with a valid package waiting.
        rst = 1'b1;
        bus.flush = 1'b0;
        present(16'h1111, 16'h2222, 7'h33, 6'h04);
        repeat (2) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("reset_idle_busy", 32'(bus.busy), 32'd0);
        check("reset_idle_done", 32'(bus.mult_done), 32'd0);

        for (int i = 0; i < 4; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].rob, vecs[i].exp);
        end

        for (int i = 0; i < 20; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rt = TAG_W'($urandom);
            rr = ROB_W'($urandom);
            run_op($sformatf("rnd%0d", i), ra, rb, rt, rr, ref_mul(ra, rb));
        end

        // Back-to-back through an upstream slot that reloads on mult_done.
        for (int i = 0; i < 3; i++) begin
            pa[i] = WIDTH'($urandom);
            pb[i] = WIDTH'($urandom);
            pt[i] = TAG_W'(i + 5);
            pr[i] = ROB_W'(i + 20);
        end
        present(pa[0], pb[0], pt[0], pr[0]);
        idx = 0;
        cyc = 0;
        last_cyc = 0;
        while (idx < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.mult_done === 1'b1) begin
                check($sformatf("b2b%0d_res", idx), 32'(bus.result), 32'(ref_mul(pa[idx], pb[idx])));
                check($sformatf("b2b%0d_tag", idx), 32'(bus.result_tag), 32'(pt[idx]));
                if (idx > 0) check($sformatf("b2b%0d_spacing", idx), 32'(cyc - last_cyc), 32'(LAT + 1));
                else check("b2b0_latency", 32'(cyc), 32'(LAT));
                last_res = ref_mul(pa[idx], pb[idx]);
                last_tag = pt[idx];
                last_rob = pr[idx];
                last_cyc = cyc;
                idx++;
                if (idx < 3) present(pa[idx], pb[idx], pt[idx], pr[idx]);
                else bus.in_valid = 1'b0;
            end
        end
        check("b2b_count", 32'(idx), 32'd3);
        @(negedge clk);

        // Flush while idle: harmless abort pulse.
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_idle_done", 32'(bus.mult_done), 32'd1);
        check("flush_idle_rv", 32'(bus.result_valid), 32'd0);
        check("flush_idle_res", 32'(bus.result), 32'(last_res));
        @(negedge clk);
        check("flush_idle_after", 32'(bus.mult_done), 32'd0);

        // Flush at the 5th BUSY cycle.
        present(16'h0123, 16'h0456, 7'h2B, 6'h0C);
        repeat (5) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_done", 32'(bus.mult_done), 32'd1);
        check("flush_rv", 32'(bus.result_valid), 32'd0);
        check("flush_res", 32'(bus.result), 32'(last_res));
        check("flush_tag", 32'(bus.result_tag), 32'(last_tag));
        check("flush_rob", 32'(bus.result_rob), 32'(last_rob));
        @(negedge clk);
        check("flush_idle", 32'(bus.busy), 32'd0);
        check("flush_no_repeat", 32'(bus.mult_done), 32'd0);
        run_op("post_flush", 16'h00FF, 16'h0101, 7'h0A, 6'h15, 16'hFFFF);

        // Reset at the 8th BUSY cycle.
        present(16'h0ABC, 16'h0003, 7'h55, 6'h2F);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check_all_zero("rst_mid");
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.mult_done !== 1'b0) saw = 1'b1;
        end
        check("rst_mid_no_done", 32'(saw), 32'd0);
        run_op("post_reset", 16'h0ABC, 16'h0003, 7'h55, 6'h2F, 16'h2034);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
